// File: rtl/clause_evaluator.sv
// Pipelined clause scan: reads one literal per cycle, classifies it against the assignment,
// and strobes the unit/conflict result. Optional early termination on a true literal: EARLY_SAT_EN.
module clause_evaluator #(
    parameter int size       = 8,
    parameter int var_num    = 8,
    parameter int clause_num = 8,
    parameter int MAX_LITS   = 8,
    localparam int VW = $clog2(var_num),
    localparam int CW = $clog2(clause_num)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [CW-1:0]   clause_id,
    input  logic [size-1:0] lit_count,
    output logic            lit_rd_en,
    output logic [CW-1:0]   lit_clause,
    output logic [size-1:0] lit_idx,
    input  logic [VW:0]     lit_data,
    input  logic [var_num-1:0] assign_val,
    input  logic [var_num-1:0] assign_def,
    output logic            busy,
    output logic            en_part_sat,
    output logic [size-1:0] counter,
    output logic [size-1:0] clause_size,
    output logic            part_sat,
    output logic            conflict,
    output logic [VW-1:0]   unit_var,
    output logic            unit_sign
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   clause_q;
    logic [size-1:0] n_q, idx_q, counter_q, unas_q, clause_size_q;
    logic            data_vld_q, sat_q, part_sat_q, conflict_q, unit_sign_q;
    logic [VW-1:0]   unit_var_q;

    logic            accept;
    logic [size-1:0] n_start, n_nxt;
    logic [VW-1:0]   lit_var;
    logic            lit_sign, var_ok, lit_def;
    logic            lit_true, lit_false, lit_unas;
    logic            sat_nxt, unas_nz_nxt;

    // Out-of-range variable indices are only possible when var_num is not a power of two.
    generate
        if (var_num < (1 << VW)) begin : g_range
            assign var_ok = (int'(lit_var) < var_num);
        end else begin : g_full
            assign var_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        lit_var   = lit_data[VW-1:0];
        lit_sign  = lit_data[VW];
        lit_def   = var_ok && assign_def[lit_var];
        lit_true  = data_vld_q && lit_def && (assign_val[lit_var] != lit_sign);
        lit_false = data_vld_q && lit_def && (assign_val[lit_var] == lit_sign);
        lit_unas  = data_vld_q && !lit_def;
    end

    always_comb begin
        accept      = start && (state_q == IDLE || state_q == DONE);
        n_start     = (lit_count > size'(MAX_LITS)) ? size'(MAX_LITS) : lit_count;
        n_nxt       = accept ? n_start : n_q;
        sat_nxt     = accept ? 1'b0 : (sat_q || lit_true);
        unas_nz_nxt = accept ? 1'b0 : ((unas_q != '0) || lit_unas);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)             state_nxt = (n_start == '0) ? DONE : READ;
                else                    state_nxt = IDLE;
            end
            READ: begin
                if (idx_q == n_q - size'(1)) state_nxt = DRAIN;
`ifdef EARLY_SAT_EN
                if (lit_true)           state_nxt = DONE;
`endif
            end
            DRAIN:                      state_nxt = DONE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lit_rd_en   = (state_q == READ);
        busy        = (state_q == READ) || (state_q == DRAIN);
        en_part_sat = (state_q == DONE);
    end

    // A read still in flight when the scan ends must not be scored into the next scan.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clause_q      <= '0;
            n_q           <= '0;
            idx_q         <= '0;
            data_vld_q    <= 1'b0;
            counter_q     <= '0;
            sat_q         <= 1'b0;
            unas_q        <= '0;
            unit_var_q    <= '0;
            unit_sign_q   <= 1'b0;
            clause_size_q <= '0;
            part_sat_q    <= 1'b0;
            conflict_q    <= 1'b0;
        end else begin
            data_vld_q <= lit_rd_en && (state_nxt == READ || state_nxt == DRAIN);
            if (accept) begin
                clause_q    <= clause_id;
                n_q         <= n_start;
                idx_q       <= '0;
                counter_q   <= '0;
                sat_q       <= 1'b0;
                unas_q      <= '0;
                unit_var_q  <= '0;
                unit_sign_q <= 1'b0;
            end else begin
                if (lit_rd_en) idx_q <= idx_q + size'(1);
                if (lit_false) counter_q <= counter_q + size'(1);
                if (lit_true)  sat_q <= 1'b1;
                if (lit_unas) begin
                    if (unas_q != '1) unas_q <= unas_q + size'(1);
                    unit_var_q  <= lit_var;
                    unit_sign_q <= lit_sign;
                end
            end
            if (state_nxt == DONE) begin
                part_sat_q    <= !sat_nxt && unas_nz_nxt;
                conflict_q    <= !sat_nxt && !unas_nz_nxt;
                clause_size_q <= (n_nxt == '0) ? '0 : n_nxt - size'(1);
            end
        end
    end

    always_comb begin
        lit_clause  = clause_q;
        lit_idx     = idx_q;
        counter     = counter_q;
        clause_size = clause_size_q;
        part_sat    = part_sat_q;
        conflict    = conflict_q;
        unit_var    = unit_var_q;
        unit_sign   = unit_sign_q;
    end

endmodule

// File: tb/tb_clause_evaluator.sv
// Directed bench for clause_evaluator: table of clause scans plus reset and back-to-back sequences.
module tb_clause_evaluator;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] clause_id;
    logic [7:0] lit_count;
    logic       lit_rd_en;
    logic [2:0] lit_clause;
    logic [7:0] lit_idx;
    logic [3:0] lit_data;
    logic [7:0] assign_val, assign_def;
    logic       busy, en_part_sat;
    logic [7:0] counter, clause_size;
    logic       part_sat, conflict;
    logic [2:0] unit_var;
    logic       unit_sign;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mem [64];

    typedef struct {
        logic [2:0] clause;
        logic [7:0] n;
        logic [7:0] aval;
        logic [7:0] adef;
        logic       restart;
        int         lat;
        int         reads;
        logic [7:0] cnt;
        logic [7:0] csize;
        logic       ps;
        logic       cf;
        logic [2:0] uv;
        logic       us;
    } vec_t;

    vec_t vecs[7];

    clause_evaluator #(.size(8), .var_num(8), .clause_num(8), .MAX_LITS(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .clause_id(clause_id),
        .lit_count(lit_count), .lit_rd_en(lit_rd_en), .lit_clause(lit_clause),
        .lit_idx(lit_idx), .lit_data(lit_data), .assign_val(assign_val),
        .assign_def(assign_def), .busy(busy), .en_part_sat(en_part_sat),
        .counter(counter), .clause_size(clause_size), .part_sat(part_sat),
        .conflict(conflict), .unit_var(unit_var), .unit_sign(unit_sign)
    );

    always #5 clock = ~clock;

    // Literal memory with one cycle read latency.
    always @(posedge clock) begin
        if (lit_rd_en) lit_data <= mem[{lit_clause, lit_idx[2:0]}];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int done_cyc = -1;
        int reads = 0;
        bit addr_ok = 1'b1;
        @(posedge clock); #1;
        assign_val = v.aval;
        assign_def = v.adef;
        clause_id  = v.clause;
        lit_count  = v.n;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (v.restart && cyc == 3) begin
                start     = 1'b1;
                clause_id = 3'd0;
                lit_count = 8'd3;
            end
            @(negedge clock);
            if (lit_rd_en) begin
                if (lit_idx != 8'(reads) || lit_clause != v.clause) addr_ok = 1'b0;
                reads++;
            end
            if (en_part_sat) done_cyc = cyc;
        end
        start = 1'b0;
        chk({tag, " latency"},     32'(done_cyc), 32'(v.lat));
        chk({tag, " reads"},       32'(reads), 32'(v.reads));
        chk({tag, " addr_seq"},    32'(addr_ok), 32'd1);
        chk({tag, " counter"},     32'(counter), 32'(v.cnt));
        chk({tag, " clause_size"}, 32'(clause_size), 32'(v.csize));
        chk({tag, " part_sat"},    32'(part_sat), 32'(v.ps));
        chk({tag, " conflict"},    32'(conflict), 32'(v.cf));
        chk({tag, " unit_var"},    32'(unit_var), 32'(v.uv));
        chk({tag, " unit_sign"},   32'(unit_sign), 32'(v.us));
        chk({tag, " busy_done"},   32'(busy), 32'd0);
    endtask

    initial begin
        int en_seen;
        reset_n = 1'b0; start = 1'b0; clause_id = '0; lit_count = '0;
        assign_val = '0; assign_def = '0; lit_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 4'b0000;
        mem[0]  = 4'b0001; mem[1]  = 4'b1010; mem[2]  = 4'b0011;
        mem[8]  = 4'b0000; mem[9]  = 4'b0001; mem[10] = 4'b1010; mem[11] = 4'b0100;
        mem[16] = 4'b1101; mem[17] = 4'b0110;
        mem[32] = 4'b1111; mem[33] = 4'b0000; mem[34] = 4'b1011;
        for (int i = 0; i < 8; i++) mem[40 + i] = {1'(i & 1), 3'(i)};
        mem[48] = 4'b1010;
        for (int i = 0; i < 5; i++) mem[56 + i] = 4'b0111;

        //          clause n      aval   adef   rst   lat rd  cnt    csize  ps    cf    uv    us
        vecs[0] = '{3'd0, 8'd3,  8'h04, 8'h06, 1'b0, 5,  3,  8'd2,  8'd2,  1'b1, 1'b0, 3'd3, 1'b0};
        vecs[1] = '{3'd1, 8'd4,  8'h02, 8'h13, 1'b0, 6,  4,  8'd2,  8'd3,  1'b0, 1'b0, 3'd2, 1'b1};
        vecs[2] = '{3'd2, 8'd2,  8'h20, 8'h60, 1'b0, 4,  2,  8'd2,  8'd1,  1'b0, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{3'd3, 8'd0,  8'h00, 8'h00, 1'b0, 1,  0,  8'd0,  8'd0,  1'b0, 1'b1, 3'd0, 1'b0};
        vecs[4] = '{3'd5, 8'd12, 8'hAA, 8'hFF, 1'b1, 10, 8,  8'd8,  8'd7,  1'b0, 1'b1, 3'd0, 1'b0};
        vecs[5] = '{3'd6, 8'd1,  8'h00, 8'h04, 1'b0, 3,  1,  8'd0,  8'd0,  1'b0, 1'b0, 3'd0, 1'b0};
        vecs[6] = '{3'd4, 8'd3,  8'h00, 8'h01, 1'b0, 5,  3,  8'd1,  8'd2,  1'b1, 1'b0, 3'd3, 1'b1};

        repeat (3) @(posedge clock); #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rd_en", 32'(lit_rd_en), 32'd0);
        chk("reset en_part_sat", 32'(en_part_sat), 32'd0);
        chk("reset outputs", 32'({counter, clause_size, part_sat, conflict, unit_var, unit_sign}), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a 5-literal scan, results from the previous scan still held.
        @(posedge clock); #1;
        clause_id = 3'd7; lit_count = 8'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("midscan busy", 32'(busy), 32'd1);
        chk("midscan held part_sat", 32'(part_sat), 32'd1);
        chk("midscan held clause_size", 32'(clause_size), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst rd_en", 32'(lit_rd_en), 32'd0);
        chk("async rst outputs",
            32'({en_part_sat, counter, clause_size, part_sat, conflict, unit_var, unit_sign}), 32'd0);
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        en_seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (en_part_sat || lit_rd_en) en_seen++;
        end
        chk("no activity after reset", 32'(en_seen), 32'd0);
        run_vec(vecs[0], "post_reset");

        // Empty clauses back to back: start held high is re-accepted in every DONE cycle.
        @(posedge clock); #1;
        clause_id = 3'd3; lit_count = 8'd0; start = 1'b1;
        en_seen = 0;
        for (int p = 1; p <= 6; p++) begin
            @(posedge clock); #1;
            if (p == 4) start = 1'b0;
            @(negedge clock);
            if (en_part_sat) en_seen++;
            if (p == 5) chk("b2b idle en", 32'(en_part_sat), 32'd0);
        end
        chk("b2b pulses", 32'(en_seen), 32'd4);
        chk("b2b conflict", 32'(conflict), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
